// File: rtl/p405s_icu_hold_reg_arb.sv
// ICU holding-register controller: round-robin arbitration among NUM_REQ loaders,
// occupancy/owner tracking and consumer handshake. Optional parity: P405S_ICU_HOLD_PARITY_EN.
module p405s_icu_hold_reg_arb #(
    parameter int NUM_REQ = 3,
    parameter int WIDTH   = 32,
    parameter int IDW     = 2
) (
    input  logic                     CB,
    input  logic                     resetL,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] reqData,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     regE1,
    output logic [WIDTH-1:0]         regD,
    output logic [WIDTH-1:0]         regL2,
    output logic                     valid,
    output logic [IDW-1:0]           ownerId,
    input  logic                     take,
    input  logic                     flush
`ifdef P405S_ICU_HOLD_PARITY_EN
    ,
    output logic                     regPar,
    output logic                     parErr
`endif
);

    localparam logic [IDW-1:0] LAST_IDX = IDW'(NUM_REQ - 1);

    logic               valid_r;
    logic [IDW-1:0]     owner_r;
    logic [IDW-1:0]     ptr_r;
    logic [WIDTH-1:0]   reg_l2_r;

    logic               slot_free_s;
    logic               found_s;
    logic               hit_s;
    logic [IDW-1:0]     cand_s;
    logic [IDW-1:0]     grant_idx_s;
    logic [IDW-1:0]     ptr_next_s;
    logic [NUM_REQ-1:0] gnt_s;
    logic [WIDTH-1:0]   reg_d_s;

    function automatic logic even_par(input logic [WIDTH-1:0] data);
        return ^data;
    endfunction

    // Round-robin search from ptr_r; slot is free when empty or being drained, never on flush.
    always_comb begin
        slot_free_s = 1'b0;
        found_s     = 1'b0;
        hit_s       = 1'b0;
        cand_s      = ptr_r;
        grant_idx_s = ptr_r;
        if (!flush && (!valid_r || take)) begin
            slot_free_s = 1'b1;
        end else begin
            slot_free_s = 1'b0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            hit_s       = slot_free_s && !found_s && req[cand_s];
            grant_idx_s = hit_s ? cand_s : grant_idx_s;
            found_s     = found_s | hit_s;
            cand_s      = (cand_s == LAST_IDX) ? '0 : cand_s + IDW'(1);
        end
    end

    // One-hot grant (suppressed in reset) and D-side mux; with no grant the mux shows reqData[ptr].
    always_comb begin
        gnt_s   = '0;
        reg_d_s = reqData[WIDTH-1:0];
        for (int j = 0; j < NUM_REQ; j++) begin
            gnt_s[j] = resetL & found_s & (grant_idx_s == IDW'(j));
            reg_d_s  = (grant_idx_s == IDW'(j)) ? reqData[j*WIDTH +: WIDTH] : reg_d_s;
        end
    end

    // Pointer advances to the requester after the winner.
    always_comb begin
        ptr_next_s = ptr_r;
        if (grant_idx_s == LAST_IDX) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = grant_idx_s + IDW'(1);
        end
    end

    // Occupancy, owner, pointer and holding register; flush outranks load and take.
    always_ff @(posedge CB or negedge resetL) begin
        if (!resetL) begin
            valid_r  <= 1'b0;
            owner_r  <= '0;
            ptr_r    <= '0;
            reg_l2_r <= '0;
        end else if (flush) begin
            valid_r  <= 1'b0;
        end else if (found_s) begin
            valid_r  <= 1'b1;
            owner_r  <= grant_idx_s;
            ptr_r    <= ptr_next_s;
            reg_l2_r <= reg_d_s;
        end else if (valid_r && take) begin
            valid_r  <= 1'b0;
        end else begin
            valid_r  <= valid_r;
        end
    end

    assign gnt     = gnt_s;
    assign regE1   = |gnt_s;
    assign regD    = reg_d_s;
    assign regL2   = reg_l2_r;
    assign valid   = valid_r;
    assign ownerId = owner_r;

`ifdef P405S_ICU_HOLD_PARITY_EN
    logic reg_par_r;

    // Parity bit is captured alongside every load of the holding register.
    always_ff @(posedge CB or negedge resetL) begin
        if (!resetL) begin
            reg_par_r <= 1'b0;
        end else if (!flush && found_s) begin
            reg_par_r <= even_par(reg_d_s);
        end else begin
            reg_par_r <= reg_par_r;
        end
    end

    assign regPar = reg_par_r;
    assign parErr = valid_r & (even_par(reg_l2_r) != reg_par_r);
`endif

endmodule

// File: tb/tb_p405s_icu_hold_reg_arb.sv
// Directed test of the ICU holding-register arbiter: reset, round-robin, back-pressure,
// flush priority, spurious take, asynchronous mid-operation reset and optional parity.
module tb_p405s_icu_hold_reg_arb;

    logic        cb;
    logic        reset_l;
    logic [2:0]  req;
    logic [95:0] req_data;
    logic [2:0]  gnt;
    logic        reg_e1;
    logic [31:0] reg_d;
    logic [31:0] reg_l2;
    logic        valid;
    logic [1:0]  owner_id;
    logic        take;
    logic        flush;
`ifdef P405S_ICU_HOLD_PARITY_EN
    logic        reg_par;
    logic        par_err;
`endif

    int tests_run;
    int tests_failed;

    localparam logic [31:0] A0 = 32'hA000_0000;
    localparam logic [31:0] A1 = 32'hA111_1111;
    localparam logic [31:0] A2 = 32'hA222_2222;

    p405s_icu_hold_reg_arb dut (
        .CB      (cb),
        .resetL  (reset_l),
        .req     (req),
        .reqData (req_data),
        .gnt     (gnt),
        .regE1   (reg_e1),
        .regD    (reg_d),
        .regL2   (reg_l2),
        .valid   (valid),
        .ownerId (owner_id),
        .take    (take),
        .flush   (flush)
`ifdef P405S_ICU_HOLD_PARITY_EN
        ,
        .regPar  (reg_par),
        .parErr  (par_err)
`endif
    );

    initial cb = 1'b0;
    always #5 cb = ~cb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge cb);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_l  = 1'b0;
        req      = 3'b001;
        req_data = {A2, A1, 32'hDEAD_BEEF};
        take     = 1'b0;
        flush    = 1'b0;

        // Reset holds everything idle even with a request pending
        #3;
        chk("rst_gnt",   32'(gnt), 32'h0);
        chk("rst_e1",    32'(reg_e1), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_l2",    reg_l2, 32'h0);
        chk("rst_owner", 32'(owner_id), 32'h0);

        // Single request after release
        tick();
        reset_l = 1'b1;
        #1;
        chk("single_gnt", 32'(gnt), 32'h1);
        chk("single_e1",  32'(reg_e1), 32'h1);
        chk("single_d",   reg_d, 32'hDEAD_BEEF);
        tick();
        req = 3'b000;
        chk("single_valid", 32'(valid), 32'h1);
        chk("single_l2",    reg_l2, 32'hDEAD_BEEF);
        chk("single_owner", 32'(owner_id), 32'h0);
        chk("single_ptr",   32'(dut.ptr_r), 32'h1);

        // Asynchronous reset mid-cycle returns pointer to 0 without a clock edge
        #2;
        reset_l = 1'b0;
        #1;
        chk("arst_valid", 32'(valid), 32'h0);
        chk("arst_l2",    reg_l2, 32'h0);
        chk("arst_ptr",   32'(dut.ptr_r), 32'h0);
        tick();
        reset_l = 1'b1;

        // Round-robin with all requesting and the consumer draining every cycle
        req_data = {A2, A1, A0};
        req  = 3'b111;
        take = 1'b1;
        #1;
        chk("rr_gnt0", 32'(gnt), 32'h1);
        tick();
        chk("rr_own0", 32'(owner_id), 32'h0);
        chk("rr_l20",  reg_l2, A0);
        chk("rr_gnt1", 32'(gnt), 32'h2);
        tick();
        chk("rr_own1", 32'(owner_id), 32'h1);
        chk("rr_val1", 32'(valid), 32'h1);
        chk("rr_gnt2", 32'(gnt), 32'h4);
        tick();
        chk("rr_own2", 32'(owner_id), 32'h2);
        chk("rr_l22",  reg_l2, A2);
        chk("rr_gnt3", 32'(gnt), 32'h1);
        tick();
        chk("rr_own3", 32'(owner_id), 32'h0);
        chk("rr_val3", 32'(valid), 32'h1);

        // Back-pressure: FULL, take low, requester 1 stalls for five cycles
        req  = 3'b010;
        take = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_gnt", 32'(gnt), 32'h0);
            chk("bp_l2",  reg_l2, A0);
            tick();
        end
        chk("bp_d_ptr", reg_d, A1);
        take = 1'b1;
        #1;
        chk("bp_release_gnt", 32'(gnt), 32'h2);
        tick();
        chk("bp_l2_new", reg_l2, A1);
        chk("bp_owner",  32'(owner_id), 32'h1);
        chk("bp_ptr",    32'(dut.ptr_r), 32'h2);

        // Take with no request drains; data and owner stay
        req = 3'b000;
        tick();
        chk("drain_valid", 32'(valid), 32'h0);
        chk("drain_l2",    reg_l2, A1);
        chk("drain_owner", 32'(owner_id), 32'h1);

        // Wrap search from ptr=2 to requester 0, then flush beats take+req
        req  = 3'b001;
        take = 1'b0;
        #1;
        chk("wrap_gnt", 32'(gnt), 32'h1);
        tick();
        chk("wrap_ptr", 32'(dut.ptr_r), 32'h1);
        req   = 3'b100;
        take  = 1'b1;
        flush = 1'b1;
        #1;
        chk("flush_gnt", 32'(gnt), 32'h0);
        chk("flush_e1",  32'(reg_e1), 32'h0);
        tick();
        chk("flush_valid", 32'(valid), 32'h0);
        chk("flush_ptr",   32'(dut.ptr_r), 32'h1);
        chk("flush_l2",    reg_l2, A0);
        flush = 1'b0;
        take  = 1'b0;
        #1;
        chk("postflush_gnt", 32'(gnt), 32'h4);
        tick();
        chk("postflush_l2",    reg_l2, A2);
        chk("postflush_owner", 32'(owner_id), 32'h2);

        // Spurious take while EMPTY
        req  = 3'b000;
        take = 1'b1;
        tick();
        tick();
        chk("spur_valid", 32'(valid), 32'h0);
        chk("spur_owner", 32'(owner_id), 32'h2);
        chk("spur_ptr",   32'(dut.ptr_r), 32'h0);

        // Load owner 1, then reset mid-cycle with a request still high
        req  = 3'b010;
        take = 1'b0;
        tick();
        chk("pre_rst_owner", 32'(owner_id), 32'h1);
        take = 1'b1;
        #2;
        reset_l = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(valid), 32'h0);
        chk("mid_rst_l2",    reg_l2, 32'h0);
        chk("mid_rst_owner", 32'(owner_id), 32'h0);
        chk("mid_rst_gnt",   32'(gnt), 32'h0);
        #1;
        reset_l = 1'b1;
        #1;
        chk("rearb_gnt", 32'(gnt), 32'h2);
        tick();
        chk("rearb_owner", 32'(owner_id), 32'h1);
        chk("rearb_l2",    reg_l2, A1);

`ifdef P405S_ICU_HOLD_PARITY_EN
        req_data = {A2, A1, 32'h0000_0007};
        req      = 3'b001;
        take     = 1'b1;
        tick();
        req = 3'b000;
        take = 1'b0;
        chk("par_l2",  reg_l2, 32'h0000_0007);
        chk("par_bit", 32'(reg_par), 32'h1);
        chk("par_err0", 32'(par_err), 32'h0);
        force dut.reg_l2_r = 32'h0000_0006;
        #1;
        chk("par_err1", 32'(par_err), 32'h1);
        release dut.reg_l2_r;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
